// File: rtl/cpu_run_sequencer.sv
// Run sequencer for the VerySimpleCPU: loads a program image into the shared RAM,
// holds the core in reset, releases it, and detects halt or watchdog expiry.
module cpu_run_sequencer #(
  parameter int unsigned          SIZE       = 14,
  parameter logic [SIZE-1:0]      HALT_ADDR  = SIZE'(14'h3FFF),
  parameter int unsigned          MAX_CYCLES = 1000000,
  parameter int unsigned          RST_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [SIZE-1:0] ld_addr,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  output logic            cpu_rst,
  input  logic            cpu_wrEn,
  input  logic [SIZE-1:0] cpu_addr,
  input  logic [31:0]     cpu_data,
  output logic            ram_wrEn,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_data,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [31:0]     cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CPURST = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] WD_LAST  = 32'(MAX_CYCLES - 1);
  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);

  state_t      state;
  logic [31:0] rst_cnt;
  logic        halt;

  assign halt = cpu_wrEn && (cpu_addr == HALT_ADDR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      timeout <= 1'b0;
      cycles  <= '0;
      rst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_LOAD;
            done    <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_last) begin
            state   <= S_CPURST;
            rst_cnt <= '0;
          end
        end
        S_CPURST: begin
          rst_cnt <= rst_cnt + 32'd1;
          if (rst_cnt == RST_LAST) state <= S_RUN;
        end
        S_RUN: begin
          if (cycles != '1) cycles <= cycles + 32'd1;
          // The halt check comes first so a simultaneous watchdog hit is not flagged.
          if (halt) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (cycles == WD_LAST) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Zero-latency mux so the CPU's same-cycle RAM addressing is preserved.
  always_comb begin
    ld_ready = 1'b0;
    cpu_rst  = 1'b1;
    busy     = 1'b0;
    ram_wrEn = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    case (state)
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        ram_wrEn = ld_valid;
        ram_addr = ld_addr;
        ram_data = ld_data;
      end
      S_CPURST: busy = 1'b1;
      S_RUN: begin
        cpu_rst  = 1'b0;
        busy     = 1'b1;
        ram_wrEn = cpu_wrEn;
        ram_addr = cpu_addr;
        ram_data = cpu_data;
      end
      default: ;
    endcase
  end

endmodule
